// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate L1 data cache.
// CPU side : data_addr/data_out/data_sel/data_rd/data_we/data_sign_ext/fence in,
//            data_in (load result) and data_ready (combinational on hit) out.
// Bus side : word-wide req/ack port; addr_o/data_o/rd_o/we_o registered,
//            data_i/ack_i in. Lines are 4 words; misses write back a dirty
//            victim, then refill one word per handshake.
module data_cache #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    output logic [31:0] data_in,
    input  logic [31:0] data_out,
    input  logic        data_we,
    input  logic        data_rd,
    input  logic [3:0]  data_sel,
    output logic        data_ready,
    input  logic        data_sign_ext,
    output logic [31:0] addr_o,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        we_o,
    output logic        rd_o,
    input  logic        ack_i,
    input  logic        fence
);
    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 32 - 4 - INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(LINES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WB, S_REFILL, S_FSCAN, S_FDONE} state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic [TAG_BITS-1:0]   ntag_q, ntag_d;
    logic [1:0]            beat_q, beat_d;
    logic                  fence_mode_q, fence_mode_d;
    logic                  rd_q, rd_d, we_q, we_d;
    logic [31:0]           addr_q, addr_d, wdat_q, wdat_d;
    logic [LINES-1:0]      valid_q, valid_d, dirty_q, dirty_d;

    logic [31:0]           line_mem [LINES][4];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];

    logic [INDEX_BITS-1:0] a_idx;
    logic [1:0]            a_off;
    logic [TAG_BITS-1:0]   a_tag;
    logic                  hit, load_hit, st_we, rf_we, tag_we, ready;
    logic                  unused_addr_lsb;

    assign a_idx           = data_addr[4 +: INDEX_BITS];
    assign a_off           = data_addr[3:2];
    assign a_tag           = data_addr[31 -: TAG_BITS];
    assign unused_addr_lsb = ^data_addr[1:0];

    assign hit      = valid_q[a_idx] && (tag_mem[a_idx] == a_tag);
    // A simultaneous rd+we is a store, so only a pure load drives data_in.
    assign load_hit = (state_q == S_IDLE) && !fence && data_rd && !data_we && hit;

    // Load formatting: extract the selected lanes, then sign/zero extend.
    always_comb begin
        logic [31:0] word;
        logic [15:0] half;
        logic [7:0]  byte_v;
        logic        is_half, is_byte;
        logic [31:0] fmt;
        word    = line_mem[a_idx][a_off];
        half    = '0;
        byte_v  = '0;
        is_half = 1'b0;
        is_byte = 1'b0;
        case (data_sel)
            4'b0011: begin is_half = 1'b1; half   = word[15:0];  end
            4'b1100: begin is_half = 1'b1; half   = word[31:16]; end
            4'b0001: begin is_byte = 1'b1; byte_v = word[7:0];   end
            4'b0010: begin is_byte = 1'b1; byte_v = word[15:8];  end
            4'b0100: begin is_byte = 1'b1; byte_v = word[23:16]; end
            4'b1000: begin is_byte = 1'b1; byte_v = word[31:24]; end
            default: ;
        endcase
        if (is_half)      fmt = {{16{data_sign_ext & half[15]}}, half};
        else if (is_byte) fmt = {{24{data_sign_ext & byte_v[7]}}, byte_v};
        else              fmt = word;
        data_in = load_hit ? fmt : 32'h0;
    end

    // Next-state / control: hit service, write-back, refill and fence walk.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ntag_d       = ntag_q;
        beat_d       = beat_q;
        fence_mode_d = fence_mode_q;
        rd_d         = rd_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdat_d       = wdat_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        ready        = 1'b0;
        st_we        = 1'b0;
        rf_we        = 1'b0;
        tag_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fence) begin
                    state_d      = S_FSCAN;
                    idx_d        = '0;
                    beat_d       = '0;
                    fence_mode_d = 1'b1;
                end else if (data_rd || data_we) begin
                    if (hit) begin
                        ready = 1'b1;
                        if (data_we) begin
                            st_we          = 1'b1;
                            dirty_d[a_idx] = 1'b1;
                        end
                    end else begin
                        idx_d        = a_idx;
                        ntag_d       = a_tag;
                        beat_d       = '0;
                        fence_mode_d = 1'b0;
                        state_d      = (valid_q[a_idx] && dirty_q[a_idx]) ? S_WB : S_REFILL;
                    end
                end
            end
            S_WB: begin
                // Request is raised only from a low cycle, giving the gap after each ack.
                if (!we_q) begin
                    we_d   = 1'b1;
                    addr_d = {tag_mem[idx_q], idx_q, beat_q, 2'b00};
                    wdat_d = line_mem[idx_q][beat_q];
                end else if (ack_i) begin
                    we_d   = 1'b0;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        if (fence_mode_q) begin
                            dirty_d[idx_q] = 1'b0;
                            if (idx_q == LAST_IDX) begin
                                state_d = S_FDONE;
                            end else begin
                                idx_d   = idx_q + INDEX_BITS'(1);
                                state_d = S_FSCAN;
                            end
                        end else begin
                            state_d = S_REFILL;
                        end
                    end
                end
            end
            S_REFILL: begin
                if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = {ntag_q, idx_q, beat_q, 2'b00};
                end else if (ack_i) begin
                    rd_d   = 1'b0;
                    rf_we  = 1'b1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        valid_d[idx_q] = 1'b1;
                        dirty_d[idx_q] = 1'b0;
                        tag_we         = 1'b1;
                        state_d        = S_IDLE;
                    end
                end
            end
            S_FSCAN: begin
                if (valid_q[idx_q] && dirty_q[idx_q]) begin
                    beat_d  = '0;
                    state_d = S_WB;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_FDONE;
                end else begin
                    idx_d = idx_q + INDEX_BITS'(1);
                end
            end
            S_FDONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and bus registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            ntag_q       <= '0;
            beat_q       <= '0;
            fence_mode_q <= 1'b0;
            rd_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdat_q       <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ntag_q       <= ntag_d;
            beat_q       <= beat_d;
            fence_mode_q <= fence_mode_d;
            rd_q         <= rd_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdat_q       <= wdat_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    // Line data and tag storage; contents are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (st_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sel[b]) line_mem[a_idx][a_off][8*b +: 8] <= data_out[8*b +: 8];
            end
        end
        if (rf_we)  line_mem[idx_q][beat_q] <= data_i;
        if (tag_we) tag_mem[idx_q] <= ntag_q;
    end

    assign rd_o       = rd_q;
    assign we_o       = we_q;
    assign addr_o     = addr_q;
    assign data_o     = wdat_q;
    assign data_ready = ready;
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: bus beats and load results are predicted into a
// scoreboard queue at stimulus time and compared as the memory model acks.
module tb_data_cache;
    logic        clk;
    logic        rst;
    logic [31:0] data_addr, data_in, data_out, addr_o, data_i, data_o;
    logic        data_we, data_rd, data_ready, data_sign_ext;
    logic [3:0]  data_sel;
    logic        we_o, rd_o, ack_i, fence;

    int n_checks = 0;
    int n_fail   = 0;
    int wcnt     = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;
    beat_t exp_q[$];

    data_cache #(.INDEX_BITS(6)) dut (
        .clk(clk), .rst(rst), .data_addr(data_addr), .data_in(data_in),
        .data_out(data_out), .data_we(data_we), .data_rd(data_rd),
        .data_sel(data_sel), .data_ready(data_ready), .data_sign_ext(data_sign_ext),
        .addr_o(addr_o), .data_i(data_i), .data_o(data_o), .we_o(we_o),
        .rd_o(rd_o), .ack_i(ack_i), .fence(fence)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic push_beat(input logic we, input logic [31:0] addr, input logic [31:0] data);
        beat_t b;
        b.we = we; b.addr = addr; b.data = data;
        exp_q.push_back(b);
    endtask

    // Refill of a line from the address-echo memory.
    task automatic push_refill(input logic [31:0] base);
        for (int k = 0; k < 4; k++) push_beat(1'b0, base + 32'(4*k), 32'h0);
    endtask

    // Memory model: acks every request on its third low-phase, returns addr as data.
    always @(negedge clk) begin
        if (!rst) begin
            ack_i = 1'b0;
            wcnt  = 0;
        end else if (ack_i) begin
            ack_i = 1'b0;
        end else if (rd_o || we_o) begin
            if (wcnt == 2) begin
                wcnt   = 0;
                ack_i  = 1'b1;
                data_i = rd_o ? addr_o : 32'h0;
                check("bus_excl", {31'b0, rd_o & we_o}, 32'h0);
                check("bus_expected", {31'b0, exp_q.size() != 0}, 32'h1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("bus_we", {31'b0, we_o}, {31'b0, e.we});
                    check("bus_addr", addr_o, e.addr);
                    if (e.we) check("bus_data", data_o, e.data);
                end
            end else begin
                wcnt++;
            end
        end
    end

    // One CPU access; entered and left just after a rising edge.
    task automatic access(input string tag, input logic rd, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [3:0] sel, input logic sext,
                          input logic exp_hit, input logic chk, input logic [31:0] exp);
        int cyc;
        data_addr = addr; data_out = wdat; data_sel = sel; data_sign_ext = sext;
        data_rd = rd; data_we = we;
        cyc = 0;
        @(negedge clk);
        while (!data_ready && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        if (!data_ready) begin
            check({tag, "_timeout"}, 32'h0, 32'h1);
        end else begin
            if (exp_hit) begin
                check({tag, "_hit_lat"}, 32'(cyc), 32'h0);
                check({tag, "_hit_nobus"}, {30'b0, rd_o, we_o}, 32'h0);
            end
            if (chk) check(tag, data_in, exp);
        end
        @(posedge clk);
        #1;
        data_rd = 1'b0;
        data_we = 1'b0;
        check({tag, "_bus_done"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic do_fence(input string tag);
        int cyc;
        fence = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!data_ready && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        if (!data_ready) check({tag, "_timeout"}, 32'h0, 32'h1);
        @(posedge clk);
        #1;
        fence = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, data_ready}, 32'h0);
        check({tag, "_bus_done"}, 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b0; ack_i = 1'b0; data_i = '0;
        data_addr = '0; data_out = '0; data_we = 1'b0; data_rd = 1'b0;
        data_sel = 4'hF; data_sign_ext = 1'b0; fence = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", {31'b0, data_ready}, 32'h0);
        check("rst_rd_o", {31'b0, rd_o}, 32'h0);
        check("rst_we_o", {31'b0, we_o}, 32'h0);
        check("rst_addr_o", addr_o, 32'h0);
        check("rst_data_o", data_o, 32'h0);
        check("rst_data_in", data_in, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss, store hit, load hit.
        push_refill(32'h0);
        access("rd_0", 1, 0, 32'h0, 32'h0, 4'hF, 0, 0, 1, 32'h0);
        access("wr_4", 0, 1, 32'h4, 32'h01234567, 4'hF, 0, 1, 0, 32'h0);
        access("rd_4", 1, 0, 32'h4, 32'h0, 4'hF, 0, 1, 1, 32'h01234567);

        // Conflict miss with dirty victim.
        push_beat(1, 32'h0, 32'h0);
        push_beat(1, 32'h4, 32'h01234567);
        push_beat(1, 32'h8, 32'h8);
        push_beat(1, 32'hC, 32'hC);
        push_refill(32'h00010000);
        access("rd_10000", 1, 0, 32'h00010000, 32'h0, 4'hF, 0, 0, 1, 32'h00010000);

        // Lane selection and extension.
        push_refill(32'h80);
        access("rd_80_sb", 1, 0, 32'h80, 32'h0, 4'b0001, 1, 0, 1, 32'hFFFFFF80);
        access("rd_80_zb", 1, 0, 32'h80, 32'h0, 4'b0001, 0, 1, 1, 32'h00000080);
        access("rd_80_hi", 1, 0, 32'h80, 32'h0, 4'b1100, 1, 1, 1, 32'h00000000);

        // Dirty index 3, then fence twice.
        push_refill(32'h30);
        access("wr_34", 0, 1, 32'h34, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0);
        push_beat(1, 32'h30, 32'h30);
        push_beat(1, 32'h34, 32'hDEADBEEF);
        push_beat(1, 32'h38, 32'h38);
        push_beat(1, 32'h3C, 32'h3C);
        do_fence("fence1");
        do_fence("fence2");

        // Byte store, then signed/unsigned byte and halfword loads.
        access("wr_81", 0, 1, 32'h80, 32'h0000F000, 4'b0010, 0, 1, 0, 32'h0);
        access("rd_81_sb", 1, 0, 32'h80, 32'h0, 4'b0010, 1, 1, 1, 32'hFFFFFFF0);
        access("rd_80_sh", 1, 0, 32'h80, 32'h0, 4'b0011, 1, 1, 1, 32'hFFFFF080);
        access("rd_80_zh", 1, 0, 32'h80, 32'h0, 4'b0011, 0, 1, 1, 32'h0000F080);
        access("rdwr_84", 1, 1, 32'h84, 32'h11223344, 4'hF, 0, 1, 0, 32'h0);
        access("rd_84", 1, 0, 32'h84, 32'h0, 4'hF, 0, 1, 1, 32'h11223344);

        // Reset in the middle of a refill.
        data_addr = 32'h00020040; data_sel = 4'hF; data_sign_ext = 1'b0; data_rd = 1'b1;
        cyc = 0;
        while (!rd_o && cyc < 50) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        check("abort_rd_seen", {31'b0, rd_o}, 32'h1);
        rst = 1'b0;
        #1;
        check("abort_rd_o", {31'b0, rd_o}, 32'h0);
        check("abort_we_o", {31'b0, we_o}, 32'h0);
        check("abort_ready", {31'b0, data_ready}, 32'h0);
        data_rd = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        push_refill(32'h00020040);
        access("rd_20040", 1, 0, 32'h00020040, 32'h0, 4'hF, 0, 0, 1, 32'h00020040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
